// File: rtl/ctrl_code_pkg.sv
// Shared decode constants: opcodes, one-hot code bit positions, skid-buffer state.
// Latency: n/a (declarations only). Backpressure: n/a.
package ctrl_code_pkg;

    localparam int CODE_W     = 10;
    localparam int CODE_J     = 0;
    localparam int CODE_JR    = 1;
    localparam int CODE_LUI   = 2;
    localparam int CODE_AUIPC = 3;
    localparam int CODE_BR    = 4;
    localparam int CODE_R     = 5;
    localparam int CODE_ST    = 6;
    localparam int CODE_I     = 7;
    localparam int CODE_LD    = 8;
    localparam int CODE_CSR   = 9;

    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_OP       = 7'b0110011;
    localparam logic [6:0] OP_OP_32    = 7'b0111011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OP_OP_IMM32 = 7'b0011011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
    localparam logic [6:0] OP_LOAD_FP  = 7'b0000111;
    localparam logic [6:0] OP_STORE_FP = 7'b0100111;
    localparam logic [6:0] OP_OP_FP    = 7'b1010011;
    localparam logic [6:0] OP_FMADD    = 7'b1000011;
    localparam logic [6:0] OP_FMSUB    = 7'b1000111;
    localparam logic [6:0] OP_FNMSUB   = 7'b1001011;
    localparam logic [6:0] OP_FNMADD   = 7'b1001111;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic              illegal;
        logic [31:0]       insn;
    } dec_t;

    function automatic logic [CODE_W-1:0] code_bit(input int idx);
        code_bit = {{(CODE_W-1){1'b0}}, 1'b1} << idx;
    endfunction

endpackage

// File: rtl/insn_classify.sv
// Opcode to one-hot class; RV64F_DECODE_EN folds FP opcodes into existing classes.
// Latency: combinational. Backpressure: none.
module insn_classify
    import ctrl_code_pkg::*;
(
    input  logic [6:0]        opcode,
    output logic [CODE_W-1:0] code,
    output logic              illegal
);

    always_comb begin
        code    = '0;
        illegal = 1'b0;
        case (opcode)
            OP_JAL:                    code = code_bit(CODE_J);
            OP_JALR:                   code = code_bit(CODE_JR);
            OP_LUI:                    code = code_bit(CODE_LUI);
            OP_AUIPC:                  code = code_bit(CODE_AUIPC);
            OP_BRANCH:                 code = code_bit(CODE_BR);
            OP_OP, OP_OP_32:           code = code_bit(CODE_R);
            OP_STORE:                  code = code_bit(CODE_ST);
            OP_OP_IMM, OP_OP_IMM32:    code = code_bit(CODE_I);
            OP_LOAD:                   code = code_bit(CODE_LD);
            OP_SYSTEM:                 code = code_bit(CODE_CSR);
`ifdef RV64F_DECODE_EN
            OP_LOAD_FP:                code = code_bit(CODE_LD);
            OP_STORE_FP:               code = code_bit(CODE_ST);
            OP_OP_FP, OP_FMADD, OP_FMSUB,
            OP_FNMSUB, OP_FNMADD:      code = code_bit(CODE_R);
`endif
            default:                   illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/insn_code_gen.sv
// Decode front end: classifies fetched instructions into a one-hot code (RV64F_DECODE_EN adds FP opcodes).
// Latency: 1 cycle in_fire -> out_valid; 1 insn/cycle sustained.
// Backpressure: 2-entry skid (M/S); registered in_ready drops only when both are full.
module insn_code_gen
    import ctrl_code_pkg::*;
#(
    parameter int PC_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_insn,
    input  logic [PC_W-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] code,
    output logic [31:0]       insn,
    output logic [PC_W-1:0]   pc,
    output logic              illegal
);

    skid_state_e       state_q, state_d;
    dec_t              in_dec, m_q, s_q;
    logic [PC_W-1:0]   m_pc_q, s_pc_q;
    logic              in_ready_q;
    logic              in_fire, out_fire;
    logic              load_m_in, load_m_s, load_s;
    logic [CODE_W-1:0] cls_code;
    logic              cls_illegal;

    insn_classify u_classify (
        .opcode  (in_insn[6:0]),
        .code    (cls_code),
        .illegal (cls_illegal)
    );

    assign in_dec   = '{code: cls_code, illegal: cls_illegal, insn: in_insn};
    assign in_ready = in_ready_q;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b1;
        end else begin
            state_q    <= state_d;
            in_ready_q <= (state_d != TWO);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (in_fire) state_d = ONE;
            ONE: begin
                if (in_fire && !out_fire)      state_d = TWO;
                else if (out_fire && !in_fire) state_d = EMPTY;
            end
            TWO:   if (out_fire) state_d = ONE;
            default: state_d = EMPTY;
        endcase
        if (flush) state_d = EMPTY;
    end

    // Loads are suppressed under flush so a same-cycle input is truly dropped.
    always_comb begin
        out_valid = (state_q != EMPTY);
        load_m_in = 1'b0;
        load_m_s  = 1'b0;
        load_s    = 1'b0;
        if (!flush) begin
            case (state_q)
                EMPTY: load_m_in = in_fire;
                ONE: begin
                    load_m_in = in_fire & out_fire;
                    load_s    = in_fire & ~out_fire;
                end
                TWO:   load_m_s = out_fire;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_q    <= '0;
            s_q    <= '0;
            m_pc_q <= '0;
            s_pc_q <= '0;
        end else begin
            if (load_m_in) begin
                m_q    <= in_dec;
                m_pc_q <= in_pc;
            end else if (load_m_s) begin
                m_q    <= s_q;
                m_pc_q <= s_pc_q;
            end
            if (load_s) begin
                s_q    <= in_dec;
                s_pc_q <= in_pc;
            end
        end
    end

    assign code    = m_q.code;
    assign illegal = m_q.illegal;
    assign insn    = m_q.insn;
    assign pc      = m_pc_q;

endmodule

// File: tb/tb_insn_code_gen.sv
// Directed bench for insn_code_gen: classification, skid backpressure, flush, async reset.
// Latency: checks one cycle after each accept. Backpressure: exercised via out_ready.
module tb_insn_code_gen;

    localparam int PC_W = 64;

`ifdef RV64F_DECODE_EN
    localparam logic [9:0] FLW_CODE = 10'h100;
    localparam logic [9:0] OPFP_CODE = 10'h020;
`else
    localparam logic [9:0] FLW_CODE = 10'h000;
    localparam logic [9:0] OPFP_CODE = 10'h000;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_insn;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [9:0]      code;
    logic [31:0]     insn;
    logic [PC_W-1:0] pc;
    logic            illegal;

    int total  = 0;
    int passed = 0;

    insn_code_gen #(.PC_W(PC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_insn   (in_insn),
        .in_pc     (in_pc),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .code      (code),
        .insn      (insn),
        .pc        (pc),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        else passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] tbl_insn [11];
    logic [9:0]  tbl_code [11];

    initial begin
        tbl_insn[0]  = 32'h0000_0067; tbl_code[0]  = 10'h002;
        tbl_insn[1]  = 32'h0000_0017; tbl_code[1]  = 10'h008;
        tbl_insn[2]  = 32'h0000_0063; tbl_code[2]  = 10'h010;
        tbl_insn[3]  = 32'h0000_003B; tbl_code[3]  = 10'h020;
        tbl_insn[4]  = 32'h0000_0023; tbl_code[4]  = 10'h040;
        tbl_insn[5]  = 32'h0000_001B; tbl_code[5]  = 10'h080;
        tbl_insn[6]  = 32'h0000_0003; tbl_code[6]  = 10'h100;
        tbl_insn[7]  = 32'h0000_0073; tbl_code[7]  = 10'h200;
        tbl_insn[8]  = 32'h0000_007F; tbl_code[8]  = 10'h000;
        tbl_insn[9]  = 32'h0000_2007; tbl_code[9]  = FLW_CODE;
        tbl_insn[10] = 32'h0000_0053; tbl_code[10] = OPFP_CODE;

        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_insn = '0; in_pc = '0; out_ready = 1'b0;
        step();
        step();
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_code", 64'(code), 64'd0);
        check("rst_illegal", 64'(illegal), 64'd0);
        check("rst_pc", pc, 64'd0);

        // First transaction: JAL
        reset = 1'b0;
        in_valid = 1'b1; in_insn = 32'h0000_006F; in_pc = 64'h1000; out_ready = 1'b1;
        step();
        check("jal_valid", 64'(out_valid), 64'd1);
        check("jal_code", 64'(code), 64'h001);
        check("jal_illegal", 64'(illegal), 64'd0);
        check("jal_pc", pc, 64'h1000);

        // Back-to-back LUI then EBREAK
        in_insn = 32'h0000_0037; in_pc = 64'h1004;
        step();
        check("lui_code", 64'(code), 64'h004);
        check("lui_pc", pc, 64'h1004);
        in_insn = 32'h0010_0073; in_pc = 64'h1008;
        step();
        check("ebreak_code", 64'(code), 64'h200);
        check("ebreak_bit20", 64'(insn[20]), 64'd1);
        check("ebreak_insn", 64'(insn), 64'h0010_0073);

        // Classification table, streamed at full rate
        for (int i = 0; i < 11; i++) begin
            in_insn = tbl_insn[i]; in_pc = 64'h2000 + 64'(i * 4);
            step();
            check($sformatf("cls%0d_code", i), 64'(code), 64'(tbl_code[i]));
            check($sformatf("cls%0d_illegal", i), 64'(illegal), 64'(tbl_code[i] == 10'h000));
            check($sformatf("cls%0d_pc", i), pc, 64'h2000 + 64'(i * 4));
        end
        in_valid = 1'b0;
        step();
        check("drain_valid", 64'(out_valid), 64'd0);

        // Backpressure: three offered, two accepted, then ordered drain
        out_ready = 1'b0;
        in_valid = 1'b1; in_insn = 32'h0000_0033; in_pc = 64'h3000;
        step();
        check("bp_a_ready", 64'(in_ready), 64'd1);
        in_insn = 32'h0000_0023; in_pc = 64'h3004;
        step();
        check("bp_b_ready", 64'(in_ready), 64'd0);
        check("bp_hold_a", 64'(code), 64'h020);
        in_insn = 32'h0000_0013; in_pc = 64'h3008;
        step();
        check("bp_still_a", 64'(code), 64'h020);
        check("bp_still_a_pc", pc, 64'h3000);
        out_ready = 1'b1;
        step();
        check("bp_b_code", 64'(code), 64'h040);
        check("bp_b_pc", pc, 64'h3004);
        step();
        check("bp_c_code", 64'(code), 64'h080);
        check("bp_c_pc", pc, 64'h3008);
        in_valid = 1'b0;
        step();
        check("bp_no_dup", 64'(out_valid), 64'd0);

        // Flush while TWO with a concurrent offer
        out_ready = 1'b0; in_valid = 1'b1; in_insn = 32'h0000_0037; in_pc = 64'h4000;
        step();
        in_pc = 64'h4004;
        step();
        check("fl_two_ready", 64'(in_ready), 64'd0);
        flush = 1'b1; in_insn = 32'h0000_006F; in_pc = 64'h4008;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_two_valid", 64'(out_valid), 64'd0);
        check("fl_two_ready_after", 64'(in_ready), 64'd1);
        out_ready = 1'b1;
        step();
        check("fl_two_dropped", 64'(out_valid), 64'd0);

        // Flush in ONE while the input actually fires
        in_valid = 1'b1; in_insn = 32'h0000_0037; in_pc = 64'h5000; out_ready = 1'b0;
        step();
        flush = 1'b1; in_insn = 32'h0000_0067; in_pc = 64'h5004;
        step();
        flush = 1'b0; in_valid = 1'b0;
        check("fl_one_valid", 64'(out_valid), 64'd0);
        step();
        check("fl_one_dropped", 64'(out_valid), 64'd0);

        // Async reset mid-cycle with a valid entry held
        in_valid = 1'b1; in_insn = 32'h0000_0003; in_pc = 64'h6000;
        step();
        in_valid = 1'b0;
        check("ar_pre_valid", 64'(out_valid), 64'd1);
        #1 reset = 1'b1;
        #1;
        check("ar_valid", 64'(out_valid), 64'd0);
        check("ar_code", 64'(code), 64'd0);
        check("ar_illegal", 64'(illegal), 64'd0);
        check("ar_pc", pc, 64'd0);
        check("ar_in_ready", 64'(in_ready), 64'd1);
        step();
        reset = 1'b0;
        step();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/insn_code_gen.md
Name: insn_code_gen

Overview:
- Decode-stage front end that classifies each fetched 32-bit instruction into the 10-bit one-hot instruction-class `code` consumed by the control-unit gate/mux network.
- Registers `code`, `insn` and `pc` behind a valid/ready handshake, with a 2-entry skid buffer for full throughput.
- Flags illegal encodings and supports a pipeline flush.
- Sits between instruction fetch and the control unit.

Parameters:
- PC_W, 64, width of the program-counter sideband carried with each instruction.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  asynchronous, active-high reset
- flush  in  1  synchronous; discards all buffered entries
- in_valid  in  1  fetch offers an instruction
- in_ready  out  1  block can accept; registered
- in_insn  in  32  raw instruction
- in_pc  in  PC_W  address of in_insn
- out_valid  out  1  a decoded entry is presented
- out_ready  in  1  control unit accepts the entry
- code  out  10  one-hot class; all zeros when illegal
- insn  out  32  instruction paired with code
- pc  out  PC_W  pc paired with code
- illegal  out  1  entry has an unrecognised encoding

Behaviour:
- Fires:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Classification (combinational on in_insn, result stored at in_fire), by opcode insn[6:0]:
  - 1101111 -> bit0 (JAL)
  - 1100111 -> bit1 (JALR)
  - 0110111 -> bit2 (LUI)
  - 0010111 -> bit3 (AUIPC)
  - 1100011 -> bit4 (BRANCH)
  - 0110011 or 0111011 -> bit5 (R)
  - 0100011 -> bit6 (STORE)
  - 0010011 or 0011011 -> bit7 (I-ALU)
  - 0000011 -> bit8 (LOAD)
  - 1110011 -> bit9 (SYSTEM)
- Any other opcode -> code=0, illegal=1.
- SYSTEM entries pass insn unchanged; downstream uses insn[20] to distinguish ECALL from EBREAK.
- Exactly one code bit is set whenever illegal=0.
- Storage: main register M drives the outputs; skid register S. States:
  - EMPTY: out_valid=0, in_ready=1. in_fire -> ONE, loading M.
  - ONE: out_valid=1, in_ready=1.
    - in_fire & !out_fire -> TWO, loading S.
    - out_fire & !in_fire -> EMPTY.
    - Both -> stay ONE, M reloaded with the new input.
  - TWO: out_valid=1, in_ready=0. out_fire -> ONE, S moves to M.
- Latency: 1 cycle from in_fire to out_valid. Sustained throughput 1 instruction per cycle while out_ready=1.
- Outputs are stable while out_valid=1 and out_ready=0.
- flush: next state is EMPTY regardless of handshakes. An in_fire in the same cycle is dropped. in_ready=1 in the following cycle.
- Reset (async, any time including mid-transfer):
  - State EMPTY; out_valid=0, in_ready=1.
  - code=0, insn=0, pc=0, illegal=0; S cleared.

Optional Feature:
- Macro: RV64F_DECODE_EN.
- Defined — floating-point opcodes map to existing classes:
  - 0000111 (LOAD-FP) -> bit8
  - 0100111 (STORE-FP) -> bit6
  - 1010011 (OP-FP) and 1000011/1000111/1001011/1001111 (FMADD family) -> bit5
- Undefined: these opcodes are illegal (code=0, illegal=1).

Decomposition:
- Package ctrl_code_pkg holds:
  - opcode localparams;
  - code bit-index constants (CODE_J=0 … CODE_CSR=9) and CODE_W=10;
  - the skid-buffer state enum (EMPTY/ONE/TWO).
- Sub-module insn_classify: purely combinational opcode -> {code, illegal}, instantiated once on the input side. The feature macro is confined to it.

Test Plan:
- Reset release, in_valid=1, in_insn=0x0000006F (JAL), out_ready=1 -> next cycle out_valid=1, code=0x001, illegal=0.
- Back-to-back inputs 0x00000037 (LUI) then 0x00100073 (EBREAK), out_ready=1 -> codes 0x004 then 0x200 on consecutive cycles; insn[20]=1 on the second.
- out_ready=0 with 3 inputs offered -> in_ready drops after the 2nd accept; raising out_ready delivers entries in order with no loss or duplication.
- in_insn=0x00002007 (FLW) -> code=0x100, illegal=0 with RV64F_DECODE_EN; code=0x000, illegal=1 without it.
- State TWO with flush=1 and in_valid=1 in the same cycle -> next cycle out_valid=0, in_ready=1; the dropped input never appears.
- Assert reset while out_valid=1 -> out_valid, code, illegal and pc go to 0 immediately without waiting for a clock edge.
